// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered 2-to-1 word multiplexer.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        SEL_E1 = 1'b0,
        SEL_E2 = 1'b1
    } mux_sel_e;

    // Even parity (XOR reduction); narrower words are zero-extended, which leaves parity unchanged.
    function automatic logic calc_even_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/mux_2x1_core.sv
// Purely combinational WIDTH-bit 2-to-1 selector: y = sel ? e2 : e1.
module mux_2x1_core
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    // Steer one operand through unchanged.
    always_comb begin
        y = e1;
        case (mux_sel_e'(sel))
            SEL_E1:  y = e1;
            SEL_E2:  y = e2;
            default: y = e1;
        endcase
    end

endmodule

// File: rtl/mux_2x1.sv
// Registered 2-to-1 word multiplexer with a registered valid flag.
// Optional sel_par output (even parity of the selected word) when MUX2X1_PARITY_EN is defined.
module mux_2x1
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] salMux,
    output logic             out_valid
`ifdef MUX2X1_PARITY_EN
    ,
    output logic             sel_par
`endif
);

    logic [WIDTH-1:0] core_y;
    logic [WIDTH-1:0] sal_mux_d, sal_mux_q;
    logic             out_valid_d, out_valid_q;

    mux_2x1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .e1  (e1),
        .e2  (e2),
        .sel (sel),
        .y   (core_y)
    );

    // Next-state: capture on valid input, otherwise hold data and drop valid.
    always_comb begin
        sal_mux_d   = sal_mux_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            sal_mux_d   = core_y;
            out_valid_d = 1'b1;
        end else begin
            sal_mux_d   = sal_mux_q;
            out_valid_d = 1'b0;
        end
    end

    // Output and valid registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sal_mux_q   <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
        end else begin
            sal_mux_q   <= sal_mux_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign salMux    = sal_mux_q;
    assign out_valid = out_valid_q;

`ifdef MUX2X1_PARITY_EN
    logic sel_par_d, sel_par_q;

    // Parity follows the data register and only updates on valid input.
    always_comb begin
        sel_par_d = sel_par_q;
        if (in_valid) begin
            sel_par_d = calc_even_parity(64'(core_y));
        end else begin
            sel_par_d = sel_par_q;
        end
    end

    // Parity register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_par_q <= 1'b0;
        end else begin
            sel_par_q <= sel_par_d;
        end
    end

    assign sel_par = sel_par_q;
`endif

endmodule

// File: tb/tb_mux_2x1.sv
// Scoreboard bench for mux_2x1: directed vectors push expected words, a monitor pops on out_valid.
module tb_mux_2x1;

    localparam int WIDTH = 32;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             par;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] e1;
    logic [WIDTH-1:0] e2;
    logic             sel;
    logic             in_valid;
    logic [WIDTH-1:0] salMux;
    logic             out_valid;
`ifdef MUX2X1_PARITY_EN
    logic             sel_par;
`endif

    exp_t exp_q[$];
    int   checks;
    int   errors;

    mux_2x1 #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .e1        (e1),
        .e2        (e2),
        .sel       (sel),
        .in_valid  (in_valid),
        .salMux    (salMux),
        .out_valid (out_valid)
`ifdef MUX2X1_PARITY_EN
        ,
        .sel_par   (sel_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    // Drive one valid transaction just after a clock edge and record its expected result.
    task automatic issue(input logic s, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] want, input logic want_par);
        exp_t e;
        @(posedge clk);
        #1;
        sel      = s;
        e1       = a;
        e2       = b;
        in_valid = 1'b1;
        e.data   = want;
        e.par    = want_par;
        exp_q.push_back(e);
    endtask

    // Monitor: every presented output must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid got salMux=%h with empty scoreboard", salMux);
                end else begin
                    e = exp_q.pop_front();
                    check("salMux", salMux, e.data);
`ifdef MUX2X1_PARITY_EN
                    check("sel_par", {{(WIDTH-1){1'b0}}, sel_par}, {{(WIDTH-1){1'b0}}, e.par});
`endif
                end
            end
        end
    end

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sel      = 1'b0;
        e1       = 32'd15;
        e2       = 32'd0;

        // Reset held two cycles with valid input present.
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check("reset_salMux", salMux, 32'd0);
            check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;

        issue(1'b0, 32'd15, 32'd10, 32'd15, 1'b0);
        issue(1'b1, 32'd20, 32'd5,  32'd5,  1'b0);
        issue(1'b1, 32'd33, 32'd11, 32'd11, 1'b1);
        issue(1'b0, 32'd1,  32'd10, 32'd1,  1'b1);
        issue(1'b0, 32'd25, 32'd999, 32'd25, 1'b1);

        // Hold: invalid input must not disturb the registered word.
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sel      = 1'b1;
        e2       = 32'd7;
        @(posedge clk);
        #2;
        check("hold_salMux", salMux, 32'd25);
        check("hold_out_valid", {31'd0, out_valid}, 32'd0);

        issue(1'b1, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        // Mid-stream reset for one edge while valid stays asserted.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        e2    = 32'h1234_5678;
        @(posedge clk);
        #2;
        check("midreset_salMux", salMux, 32'd0);
        check("midreset_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        issue(1'b0, 32'h0000_0007, 32'd0,          32'h0000_0007, 1'b1);
        issue(1'b1, 32'd0,         32'h0000_0003, 32'h0000_0003, 1'b0);
        issue(1'b1, 32'h0000_1234, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0);
        issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);

        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d outstanding expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
